// File: rtl/hs_mux_rr.sv
// N-input valid/ready mux, static-select or round-robin; HS_MUX_RR_LOCK_EN adds in_last/out_last packet locking.
// Latency: 1 cycle from input transfer to registered out_valid/out_data/out_src.
// Backpressure: in_ready is combinational and only asserts when the output register is empty or draining.
module hs_mux_rr #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int SELW   = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [SELW-1:0]         sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SELW-1:0]         out_src,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef HS_MUX_RR_LOCK_EN
    ,
    input  logic [NUM_IN-1:0]       in_last,
    output logic                    out_last
`endif
);

    logic             load;
    logic             xfer;
    logic             gvalid;
    logic [SELW-1:0]  grant;
    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  ptr_nxt;
    logic             rr_found;
    logic [SELW-1:0]  rr_grant;
    logic [SELW:0]    rr_sum;
    logic [SELW-1:0]  rr_cand;
    logic [WIDTH-1:0] gdata;
    logic             last_beat;

`ifdef HS_MUX_RR_LOCK_EN
    logic             locked;
    logic [SELW-1:0]  lock_ch;

    assign last_beat = in_last[grant];
`else
    assign last_beat = 1'b1;
`endif

    assign load = !out_valid || out_ready;

    // Round-robin scan starts at ptr; index wraps modulo NUM_IN, not 2^SELW.
    always_comb begin
        rr_found = 1'b0;
        rr_grant = ptr;
        rr_sum   = '0;
        rr_cand  = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            rr_sum  = {1'b0, ptr} + (SELW+1)'(k);
            rr_cand = (rr_sum >= (SELW+1)'(NUM_IN)) ? SELW'(rr_sum - (SELW+1)'(NUM_IN))
                                                    : rr_sum[SELW-1:0];
            if (!rr_found && in_valid[rr_cand]) begin
                rr_found = 1'b1;
                rr_grant = rr_cand;
            end
        end
    end

    always_comb begin
        grant  = sel;
        gvalid = (32'(sel) < NUM_IN) && in_valid[sel];
        if (mode) begin
            grant  = rr_grant;
            gvalid = rr_found;
        end
`ifdef HS_MUX_RR_LOCK_EN
        if (locked) begin
            grant  = lock_ch;
            gvalid = in_valid[lock_ch];
        end
`endif
    end

    // gvalid already implies in_valid[grant], so xfer is the transfer condition.
    assign xfer = !rst && load && gvalid;

    always_comb begin
        in_ready = '0;
        gdata    = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant == SELW'(i)) begin
                in_ready[i] = xfer;
                gdata       = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_nxt = (grant == SELW'(NUM_IN-1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
`ifdef HS_MUX_RR_LOCK_EN
            out_last  <= 1'b0;
            locked    <= 1'b0;
            lock_ch   <= '0;
`endif
        end else if (load) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= gdata;
                out_src  <= grant;
                if (mode && last_beat)
                    ptr <= ptr_nxt;
`ifdef HS_MUX_RR_LOCK_EN
                out_last <= in_last[grant];
                locked   <= !in_last[grant];
                lock_ch  <= grant;
`endif
            end
        end
    end

endmodule

// File: tb/tb_hs_mux_rr.sv
// Scoreboard bench for hs_mux_rr: expected beats queued at drive time, popped when the consumer takes them.
module tb_hs_mux_rr;
    localparam int WIDTH  = 8;
    localparam int NUM_IN = 4;
    localparam int SELW   = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    mode;
    logic [SELW-1:0]         sel;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SELW-1:0]         out_src;
    logic                    out_valid;
    logic                    out_ready;
`ifdef HS_MUX_RR_LOCK_EN
    logic [NUM_IN-1:0]       in_last;
    logic                    out_last;
`endif

    typedef struct packed {
        logic [SELW-1:0]  src;
        logic [WIDTH-1:0] dat;
    } beat_t;

    beat_t sb[$];
    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    hs_mux_rr #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef HS_MUX_RR_LOCK_EN
        , .in_last(in_last), .out_last(out_last)
`endif
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; sel = '0; in_valid = 4'hF; out_ready = 1'b1;
        in_data = {8'h13, 8'h12, 8'h11, 8'h10};
`ifdef HS_MUX_RR_LOCK_EN
        in_last = '0;
`endif
        for (int c = 0; c < 2; c++) begin
            cyc();
            total_cnt++;
            if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid);
            else pass_cnt++;
            total_cnt++;
            if (out_data !== 8'h00) $display("FAIL reset_data: got %h want 00", out_data);
            else pass_cnt++;
            total_cnt++;
            if (in_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", in_ready);
            else pass_cnt++;
        end
        rst = 1'b0;
        #1;
        total_cnt++;
        if (in_ready !== 4'b0001) $display("FAIL reset_release_ready: got %b want 0001", in_ready);
        else pass_cnt++;
        sb.push_back('{src: 2'd0, dat: 8'h10});
        cyc();
        total_cnt++;
        if (out_valid !== 1'b1) $display("FAIL reset_first_beat: got %b want 1", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_static();
        beat_t e;
        logic [3:0] vt [2] = '{4'b0100, 4'b0100};
        logic [1:0] st [2] = '{2'd2, 2'd3};
        logic [3:0] rt [2] = '{4'b0100, 4'b0000};
        mode = 1'b0;
        in_data[2*WIDTH +: WIDTH] = 8'hA5;
        for (int k = 0; k < 2; k++) begin
            sel = st[k]; in_valid = vt[k];
            #1;
            total_cnt++;
            if (in_ready !== rt[k]) $display("FAIL static_ready%0d: got %b want %b", k, in_ready, rt[k]);
            else pass_cnt++;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                total_cnt++;
                if (sb.size() == 0) $display("FAIL static_beat: unexpected src=%0d data=%h", out_src, out_data);
                else begin
                    e = sb.pop_front();
                    if ({out_src, out_data} !== e)
                        $display("FAIL static_beat: got src=%0d data=%h want src=%0d data=%h", out_src, out_data, e.src, e.dat);
                    else pass_cnt++;
                end
            end
            if (k == 0) sb.push_back('{src: 2'd2, dat: 8'hA5});
            cyc();
            total_cnt++;
            if (out_valid !== (k == 0)) $display("FAIL static_valid%0d: got %b want %b", k, out_valid, (k == 0));
            else pass_cnt++;
        end
        total_cnt++;
        if ({out_src, out_data} !== {2'd2, 8'hA5})
            $display("FAIL static_hold: got src=%0d data=%h want src=2 data=a5", out_src, out_data);
        else pass_cnt++;
    endtask

    task automatic test_rr_fair();
        beat_t e;
        logic [3:0] er;
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        in_data = {8'h23, 8'h22, 8'h21, 8'h20};
        for (int i = 0; i < 8; i++) begin
            er = 4'(1 << (i % 4));
            #1;
            total_cnt++;
            if (in_ready !== er) $display("FAIL rr_fair_ready%0d: got %b want %b", i, in_ready, er);
            else pass_cnt++;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                total_cnt++;
                if (sb.size() == 0) $display("FAIL rr_fair_beat: unexpected src=%0d data=%h", out_src, out_data);
                else begin
                    e = sb.pop_front();
                    if ({out_src, out_data} !== e)
                        $display("FAIL rr_fair_beat: got src=%0d data=%h want src=%0d data=%h", out_src, out_data, e.src, e.dat);
                    else pass_cnt++;
                end
            end
            sb.push_back('{src: 2'(i % 4), dat: 8'(8'h20 + i % 4)});
            cyc();
            total_cnt++;
            if (out_valid !== 1'b1) $display("FAIL rr_fair_valid%0d: got %b want 1", i, out_valid);
            else pass_cnt++;
        end
    endtask

    task automatic test_rr_wrap();
        beat_t e;
        logic [3:0] vt [4] = '{4'b0100, 4'b0010, 4'b1001, 4'b1111};
        logic [1:0] gt [4] = '{2'd2, 2'd1, 2'd3, 2'd0};
        logic [3:0] er;
        in_data = {8'h33, 8'h32, 8'h31, 8'h30};
        for (int k = 0; k < 4; k++) begin
            in_valid = vt[k];
            er = 4'(1 << gt[k]);
            #1;
            total_cnt++;
            if (in_ready !== er) $display("FAIL rr_wrap_ready%0d: got %b want %b", k, in_ready, er);
            else pass_cnt++;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                total_cnt++;
                if (sb.size() == 0) $display("FAIL rr_wrap_beat: unexpected src=%0d data=%h", out_src, out_data);
                else begin
                    e = sb.pop_front();
                    if ({out_src, out_data} !== e)
                        $display("FAIL rr_wrap_beat: got src=%0d data=%h want src=%0d data=%h", out_src, out_data, e.src, e.dat);
                    else pass_cnt++;
                end
            end
            sb.push_back('{src: gt[k], dat: 8'(8'h30 + gt[k])});
            cyc();
        end
    endtask

    task automatic test_backpressure();
        beat_t e;
        in_valid = 4'hF; out_ready = 1'b1;
        in_data = {8'h43, 8'h42, 8'h41, 8'h40};
        for (int k = 0; k < 5; k++) begin
            out_ready = (k == 0 || k == 4);
            if (k == 2) in_data[WIDTH +: WIDTH] = 8'h5A;
            #1;
            total_cnt++;
            if (in_ready !== (k == 0 ? 4'b0010 : k == 4 ? 4'b0100 : 4'b0000))
                $display("FAIL bp_ready%0d: got %b", k, in_ready);
            else pass_cnt++;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                total_cnt++;
                if (sb.size() == 0) $display("FAIL bp_beat: unexpected src=%0d data=%h", out_src, out_data);
                else begin
                    e = sb.pop_front();
                    if ({out_src, out_data} !== e)
                        $display("FAIL bp_beat: got src=%0d data=%h want src=%0d data=%h", out_src, out_data, e.src, e.dat);
                    else pass_cnt++;
                end
            end
            if (k == 0) sb.push_back('{src: 2'd1, dat: 8'h41});
            if (k == 4) sb.push_back('{src: 2'd2, dat: 8'h42});
            cyc();
            if (k >= 1 && k <= 3) begin
                total_cnt++;
                if ({out_valid, out_src, out_data} !== {1'b1, 2'd1, 8'h41})
                    $display("FAIL bp_hold%0d: got v=%b src=%0d data=%h want v=1 src=1 data=41", k, out_valid, out_src, out_data);
                else pass_cnt++;
            end
        end
        in_valid = 4'b0000;
        #1;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            total_cnt++;
            if (sb.size() == 0) $display("FAIL bp_beat: unexpected src=%0d data=%h", out_src, out_data);
            else begin
                e = sb.pop_front();
                if ({out_src, out_data} !== e)
                    $display("FAIL bp_beat: got src=%0d data=%h want src=%0d data=%h", out_src, out_data, e.src, e.dat);
                else pass_cnt++;
            end
        end
        cyc();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL bp_idle_valid: got %b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (sb.size() != 0) $display("FAIL bp_sb_empty: got %0d beats left want 0", sb.size());
        else pass_cnt++;
    endtask

`ifdef HS_MUX_RR_LOCK_EN
    task automatic test_lock();
        beat_t e;
        logic [3:0] vt [6] = '{4'b0011, 4'b0010, 4'b0011, 4'b0011, 4'b0010, 4'b0000};
        logic       lt [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0] rt [6] = '{4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0010, 4'b0000};
        logic       ol [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        mode = 1'b1; out_ready = 1'b1;
        in_data = {8'h73, 8'h72, 8'h51, 8'h60};
        for (int k = 0; k < 6; k++) begin
            in_valid = vt[k];
            in_last  = {3'b000, lt[k]};
            in_data[WIDTH-1:0] = 8'(8'h60 + k);
            #1;
            total_cnt++;
            if (in_ready !== rt[k]) $display("FAIL lock_ready%0d: got %b want %b", k, in_ready, rt[k]);
            else pass_cnt++;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                total_cnt++;
                if (sb.size() == 0) $display("FAIL lock_beat: unexpected src=%0d data=%h", out_src, out_data);
                else begin
                    e = sb.pop_front();
                    if ({out_src, out_data} !== e)
                        $display("FAIL lock_beat: got src=%0d data=%h want src=%0d data=%h", out_src, out_data, e.src, e.dat);
                    else pass_cnt++;
                end
            end
            if (rt[k] == 4'b0001) sb.push_back('{src: 2'd0, dat: 8'(8'h60 + k)});
            if (rt[k] == 4'b0010) sb.push_back('{src: 2'd1, dat: 8'h51});
            cyc();
            total_cnt++;
            if (out_last !== ol[k]) $display("FAIL lock_last%0d: got %b want %b", k, out_last, ol[k]);
            else pass_cnt++;
        end
        total_cnt++;
        if (out_valid !== 1'b0 || sb.size() != 0)
            $display("FAIL lock_drain: got v=%b left=%0d want v=0 left=0", out_valid, sb.size());
        else pass_cnt++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_static();
        test_rr_fair();
        test_rr_wrap();
        test_backpressure();
`ifdef HS_MUX_RR_LOCK_EN
        test_lock();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
